// File: rtl/btn_event_pkg.sv
// ============================================================================
//  Module   : btn_event_pkg
//  Purpose  : Shared types and default constants for the button event
//             detector: FSM state encoding and default timing values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_event_pkg;

    // Button FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Defaults for a 25 MHz clock: 1 s long-press, 200 ms auto-repeat
    localparam int DEF_LONG_CYCLES   = 25_000_000;
    localparam int DEF_REPEAT_CYCLES = 5_000_000;
    localparam int DEF_CNT_W         = 25;

endpackage : btn_event_pkg

`default_nettype wire

// File: rtl/btn_event_if.sv
// ============================================================================
//  Module   : btn_event_if
//  Purpose  : Groups the button input level and the event outputs of the
//             button event detector.
//  Signals  : btn_level     - debounced, clk-synchronous level, 1 = pressed
//             press_pulse   - one-cycle strobe on press
//             release_pulse - one-cycle strobe on release
//             long_pulse    - one-cycle strobe when hold reaches long time
//             repeat_pulse  - one-cycle strobe on each auto-repeat period
//             held          - level, 1 while the button FSM is not idle
//  Modports : master - drives btn_level, observes events
//             slave  - the detector: samples btn_level, drives events
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface btn_event_if;

    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  held
    );

    modport slave (
        input  btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output repeat_pulse,
        output held
    );

endinterface : btn_event_if

`default_nettype wire

// File: rtl/btn_event_timer.sv
// ============================================================================
//  Module   : btn_event_timer
//  Purpose  : Hold/repeat counter with synchronous clear, count enable and a
//             terminal-count compare against a runtime-selected value.
//  Ports    : clk      - system clock, rising edge
//             reset    - synchronous, active-high reset
//             clear    - zero the counter (has priority over enable)
//             enable   - increment the counter by one
//             term_val - terminal value compared against the current count
//             tc       - 1 while count equals term_val
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_timer #(
    parameter int CNT_W = 25
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             enable,
    input  wire logic [CNT_W-1:0] term_val,
    output logic                  tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The owning FSM clears on every terminal count, so the counter never
    // reaches the wrap point for any legal terminal value.
    assign tc = (count_q == term_val);

endmodule : btn_event_timer

`default_nettype wire

// File: rtl/btn_event.sv
// ============================================================================
//  Module   : btn_event
//  Purpose  : Turns a debounced button level into press, release, long-press
//             and auto-repeat strobes plus a registered "held" level.
//  Ports    : clk   - system clock, rising edge
//             reset - synchronous, active-high reset
//             bus   - btn_event_if.slave (btn_level in; press_pulse,
//                     release_pulse, long_pulse, repeat_pulse, held out)
//  Params   : LONG_CYCLES   - hold cycles from press to long_pulse
//             REPEAT_CYCLES - cycles between repeat_pulse strobes
//             CNT_W         - width of the shared hold/repeat counter
//  Config   : BTN_EVENT_REPEAT_EN - when defined, LONG emits repeat_pulse
//             every REPEAT_CYCLES; when undefined, repeat_pulse stays 0 and
//             the counter is parked at 0 in LONG.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  wire logic  clk,
    input  wire logic  reset,
    btn_event_if.slave bus
);

`ifdef BTN_EVENT_REPEAT_EN
    localparam bit REPEAT_EN = 1'b1;
`else
    localparam bit REPEAT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

    state_t state_q;
    state_t state_d;

    logic press_q,   press_d;
    logic release_q, release_d;
    logic long_q,    long_d;
    logic repeat_q,  repeat_d;
    logic held_q,    held_d;

    logic             w_tc;
    logic             w_clear;
    logic             w_enable;
    logic [CNT_W-1:0] w_term;

    // One counter serves both phases; the compare value follows the state.
    assign w_term = (state_q == ST_LONG) ? REPEAT_TERM : LONG_TERM;

    btn_event_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .enable   (w_enable),
        .term_val (w_term),
        .tc       (w_tc)
    );

    // ------------------------------------------------------------------
    // State register (outputs registered alongside)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; release is tested before terminal count so that a
    // simultaneous release suppresses the long transition.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.btn_level) begin
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                end else if (w_tc) begin
                    state_d = ST_LONG;
                end
            end
            ST_LONG: begin
                if (!bus.btn_level) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / timer-control logic. The strobe conditions are mutually
    // exclusive by construction (disjoint state/btn_level combinations).
    // ------------------------------------------------------------------
    always_comb begin
        press_d   = (state_q == ST_IDLE) && bus.btn_level;
        release_d = (state_q != ST_IDLE) && !bus.btn_level;
        long_d    = (state_q == ST_PRESSED) && bus.btn_level && w_tc;
        repeat_d  = REPEAT_EN && (state_q == ST_LONG) && bus.btn_level && w_tc;
        held_d    = (state_d != ST_IDLE);

        w_clear   = (state_d != state_q) || repeat_d;
        w_enable  = ((state_q == ST_PRESSED) && bus.btn_level)
                  || (REPEAT_EN && (state_q == ST_LONG));
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;

endmodule : btn_event

`default_nettype wire

// File: tb/tb_btn_event.sv
// ============================================================================
//  Module   : tb_btn_event
//  Purpose  : Directed scoreboard bench for btn_event with LONG_CYCLES=10,
//             REPEAT_CYCLES=4. The driver pushes the hand-derived expected
//             output vector for the cycle following each edge; an
//             independent monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event;

    logic clk = 1'b0;
    logic reset = 1'b1;

    btn_event_if bus_if ();

    btn_event #(
        .LONG_CYCLES   (10),
        .REPEAT_CYCLES (4),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // {press, release, long, repeat, held}
    typedef struct {
        logic [4:0] v;
        int         id;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares the DUT outputs of each cycle against the oldest
    // queued expectation, sampled 1 time unit after the rising edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [4:0] got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus_if.press_pulse, bus_if.release_pulse, bus_if.long_pulse,
                   bus_if.repeat_pulse, bus_if.held};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL scen%0d cyc%0d {press,rel,long,rep,held}: got %b expected %b",
                         e.id, e.cyc, got, e.v);
            end
        end
    end

    function automatic logic [31:0] bm(input int c);
        return 32'd1 << c;
    endfunction

    function automatic logic [31:0] rng(input int a, input int b);
        logic [31:0] m = '0;
        for (int i = a; i <= b; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic drive_one(input int id, input int cyc, input logic rst,
                             input logic lvl, input logic [4:0] v);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        bus_if.btn_level = lvl;
        e.v   = v;
        e.id  = id;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    // Scenario: btn_level=1 on local edges on..off-1, reset on edge rst_k.
    // Masks give, per local cycle c (bit c), the expected output levels.
    task automatic run(input int id, input int n, input int on, input int off,
                       input int rst_k, input logic [31:0] pm, input logic [31:0] rm,
                       input logic [31:0] lm, input logic [31:0] qm,
                       input logic [31:0] hm);
        for (int k = 0; k < n; k++) begin
            drive_one(id, k + 1, (k == rst_k), (k >= on && k < off),
                      {pm[k+1], rm[k+1], lm[k+1], qm[k+1], hm[k+1]});
        end
    endtask

    logic [31:0] s2_rep;

    initial begin
        bus_if.btn_level = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
        s2_rep = bm(15) | bm(19);
`else
        s2_rep = '0;
`endif
        // Reset overrides a pressed button; then idle
        for (int k = 0; k < 3; k++) drive_one(0, k + 1, 1'b1, 1'b1, 5'b00000);
        for (int k = 3; k < 5; k++) drive_one(0, k + 1, 1'b0, 1'b0, 5'b00000);

        // Short press: edges 5..7 high
        run(1, 12, 5, 8, -1, bm(6), bm(9), '0, '0, rng(6, 8));
        // Hold 20 cycles: long at 11, repeats at 15/19 (macro on)
        run(2, 24, 0, 20, -1, bm(1), bm(21), bm(11), s2_rep, rng(1, 20));
        // Release exactly at the long terminal edge: release wins
        run(3, 13, 0, 10, -1, bm(1), bm(11), '0, '0, rng(1, 10));
        // Reset in LONG with button still down: fresh press afterwards
        run(4, 20, 0, 16, 13, bm(1) | bm(15), bm(17), bm(11), '0,
            rng(1, 13) | rng(15, 16));
        // Single-cycle press
        run(5, 6, 2, 3, -1, bm(3), bm(4), '0, '0, bm(3));
        // Release exactly at a repeat terminal edge: no repeat
        run(6, 17, 0, 14, -1, bm(1), bm(15), bm(11), '0, rng(1, 14));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_btn_event

`default_nettype wire

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter: LONG_CYCLES, 25000000, held cycles from press to long_pulse (1 s at 25 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter: REPEAT_CYCLES, 5000000, cycles between successive repeat_pulse (200 ms at 25 MHz); legal range 2..2^CNT_W-1.
REQ-003 Parameter: CNT_W, 25, width of the shared hold/repeat counter.
REQ-004 Port: clk  input  1  system clock; all logic on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: btn_level  input  1  debounced button level, clk-synchronous, 1 = pressed.
REQ-007 Port: press_pulse  output  1  one-cycle strobe on press.
REQ-008 Port: release_pulse  output  1  one-cycle strobe on release.
REQ-009 Port: long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES.
REQ-010 Port: repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES after long_pulse.
REQ-011 Port: held  output  1  registered level, 1 while FSM is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, PRESSED and LONG; all outputs registered, no combinational input-to-output path.
REQ-013 IDLE with btn_level=1 sampled at edge N: go to PRESSED, clear counter, press_pulse=1 and held=1 during the cycle after edge N.
REQ-014 PRESSED: counter increments each cycle while btn_level=1; at edge where counter==LONG_CYCLES-1, go to LONG, clear counter, long_pulse=1 for one cycle.
REQ-015 LONG: counter increments each cycle; at edge where counter==REPEAT_CYCLES-1, repeat_pulse=1 for one cycle, clear counter, stay in LONG.
REQ-016 PRESSED or LONG with btn_level=0: go to IDLE, release_pulse=1 for one cycle, held=0, counter cleared.
REQ-017 Release and counter terminal count at the same edge: release wins; no long_pulse/repeat_pulse emitted.
REQ-018 Each strobe SHALL be high for exactly one cycle; at most one strobe asserted in any cycle.
REQ-019 Counter SHALL never wrap; it is cleared on every state transition and on every terminal count.
REQ-020 One-cycle press (high at one edge, low at the next): press_pulse then release_pulse on consecutive cycles.

Reset
REQ-021 reset=1 at an edge: state=IDLE, counter=0, all five outputs 0 in the following cycle, overriding all other events.
REQ-022 reset mid-hold: no release_pulse emitted; if btn_level is still 1 after reset deasserts, a fresh press_pulse is emitted per REQ-013.

Configuration
REQ-023 Macro BTN_EVENT_REPEAT_EN defined: repeat behaviour per REQ-015.
REQ-024 BTN_EVENT_REPEAT_EN undefined: repeat_pulse tied 0, counter held at 0 in LONG, LONG waits only for release; port list unchanged.

Structure
REQ-025 Package btn_event_pkg SHALL hold the state enum typedef and default LONG_CYCLES/REPEAT_CYCLES constants.
REQ-026 Sub-module btn_event_timer (clear, enable, terminal-count compare, CNT_W wide) SHALL implement the counter; FSM stays in btn_event.

Verification (LONG_CYCLES=10, REPEAT_CYCLES=4)
REQ-027 btn_level 0->1 at edge 5, held 3 cycles, then 0 -> press_pulse cycle 6, release_pulse cycle 9, no long_pulse, held=1 cycles 6..8.
REQ-028 btn_level held 1 for 20 cycles from edge 0 -> press_pulse cycle 1, long_pulse cycle 11, repeat_pulse cycles 15 and 19 (none with macro off).
REQ-029 btn_level drops at exactly the edge where long_pulse would fire -> release_pulse only, no long_pulse.
REQ-030 reset asserted 1 cycle during LONG with btn_level=1 -> all outputs 0, no release_pulse, press_pulse 1 cycle after reset deasserts.
REQ-031 Single-cycle btn_level=1 pulse -> press_pulse and release_pulse on consecutive cycles, held=1 for exactly 1 cycle.
